// File: rtl/ble6_ccff_loader.sv
// ble6_ccff_loader: configuration-chain loader and verifier for one ble6
// logic element. Bitstream words arrive on a valid/ready stream. A one-word
// holding register feeds a word shifter, which drives one bit per cycle onto
// ccff_head. In VERIFY mode ccff_tail is compared against the shifted bit.
module ble6_ccff_loader #(
  parameter int CHAIN_LEN = 66,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start_load,
  input  logic              start_vfy,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              vfy_err
);

  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BC_W      = $clog2(CHAIN_LEN + 1);
  localparam int WA_W      = $clog2(NUM_WORDS + 1);
  localparam int SC_W      = $clog2(WORD_W + 1);

  localparam logic [BC_W-1:0] BC_TERM = BC_W'(CHAIN_LEN);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(CHAIN_LEN - 1);
  localparam logic [WA_W-1:0] WA_TERM = WA_W'(NUM_WORDS);
  localparam logic [SC_W-1:0] SC_FULL = SC_W'(WORD_W);
  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_v_q, hold_v_d;
  logic [WORD_W-1:0] shf_q, shf_d;
  logic              shf_v_q, shf_v_d;
  logic [SC_W-1:0]   shf_cnt_q, shf_cnt_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WA_W-1:0]   words_acc_q, words_acc_d;
  logic              vfy_err_q, vfy_err_d;

  logic active;
  logic xfer;
  logic shf_last;
  logic pass_end;

  assign active   = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign cfg_ready = active && !hold_v_q && (words_acc_q < WA_TERM);
  assign xfer     = cfg_valid && cfg_ready;
  // Shifter is on the final bit of its current word.
  assign shf_last = shf_v_q && (shf_cnt_q == SC_ONE);
  // This cycle's shift is the last one the chain needs; the upper bits of
  // a partial final word are simply never shifted.
  assign pass_end = shf_v_q && (bit_cnt_q == BC_LAST);

  assign ccff_shift = shf_v_q;
  assign ccff_head  = shf_v_q & shf_q[0];
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign vfy_err    = vfy_err_q;

  // Next-state, holding register / shifter refill and counters.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    shf_d       = shf_q;
    shf_v_d     = shf_v_q;
    shf_cnt_d   = shf_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    words_acc_d = words_acc_q;
    vfy_err_d   = vfy_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_load || start_vfy) begin
          state_d     = start_load ? S_LOAD : S_VERIFY;
          hold_v_d    = 1'b0;
          shf_v_d     = 1'b0;
          shf_cnt_d   = '0;
          bit_cnt_d   = '0;
          words_acc_d = '0;
          if (!start_load) vfy_err_d = 1'b0;
        end
      end

      S_LOAD, S_VERIFY: begin
        if (shf_v_q) begin
          shf_d     = shf_q >> 1;
          shf_cnt_d = shf_cnt_q - SC_ONE;
          if (bit_cnt_q != BC_TERM) bit_cnt_d = bit_cnt_q + BC_W'(1);
          // Chain already holds this data, so tail must echo head.
          if ((state_q == S_VERIFY) && (ccff_tail != shf_q[0])) vfy_err_d = 1'b1;
        end
        // Refill on empty or last bit so a steady source never bubbles.
        if (!shf_v_q || shf_last) begin
          if (hold_v_q) begin
            shf_d     = hold_q;
            shf_cnt_d = SC_FULL;
            shf_v_d   = 1'b1;
            hold_v_d  = 1'b0;
          end else if (xfer) begin
            shf_d     = cfg_data;
            shf_cnt_d = SC_FULL;
            shf_v_d   = 1'b1;
          end else begin
            shf_v_d   = 1'b0;
          end
        end else if (xfer) begin
          hold_d   = cfg_data;
          hold_v_d = 1'b1;
        end
        if (xfer && (words_acc_q != WA_TERM)) words_acc_d = words_acc_q + WA_W'(1);
        if (pass_end) begin
          state_d  = S_DONE;
          hold_v_d = 1'b0;
          shf_v_d  = 1'b0;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort drops the pass without a done pulse; vfy_err is kept.
    if (abort) begin
      state_d     = S_IDLE;
      hold_v_d    = 1'b0;
      shf_v_d     = 1'b0;
      shf_cnt_d   = '0;
      bit_cnt_d   = '0;
      words_acc_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      shf_q       <= '0;
      shf_v_q     <= 1'b0;
      shf_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      words_acc_q <= '0;
      vfy_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      shf_q       <= shf_d;
      shf_v_q     <= shf_v_d;
      shf_cnt_q   <= shf_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      words_acc_q <= words_acc_d;
      vfy_err_q   <= vfy_err_d;
    end
  end

endmodule

// File: tb/tb_ble6_ccff_loader.sv
// Bench for ble6_ccff_loader: table of passes (load/verify, stalls, abort,
// protocol pokes) with a scoreboard of expected ccff_head bits and a
// behavioural model of the 66-bit ccff chain.
module tb_ble6_ccff_loader;

  localparam int CL = 66;
  localparam int WW = 8;
  localparam int NW = 9;
  localparam int PASS_CYC = 80;

  logic          prog_clk = 1'b0;
  logic          pReset_n;
  logic          start_load, start_vfy, abort, cfg_valid;
  logic [WW-1:0] cfg_data;
  logic          cfg_ready, ccff_head, ccff_shift, ccff_tail;
  logic          busy, done, vfy_err;

  logic [CL-1:0] chain = '0;

  int n_chk = 0;
  int n_err = 0;
  bit q[$];

  typedef struct {
    bit vfy;
    bit both;
    int flip;
    int stall_after;
    int stall_len;
    int poke;
    int abort_cyc;
    int exp_last;
    bit exp_vfy;
  } row_t;

  row_t rows[10];

  ble6_ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start_load(start_load),
    .start_vfy(start_vfy), .abort(abort), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
    .ccff_shift(ccff_shift), .ccff_tail(ccff_tail), .busy(busy),
    .done(done), .vfy_err(vfy_err)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: bit shifted in first ends up at the tail.
  always @(posedge prog_clk) if (ccff_shift) chain <= {ccff_head, chain[CL-1:1]};
  assign ccff_tail = chain[0];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] word(input int k, input int flip);
    logic [WW-1:0] w;
    w = WW'(k + 1);
    if (flip >= 0 && flip / WW == k) w[flip % WW] = ~w[flip % WW];
    return w;
  endfunction

  task automatic run_pass(input int idx, input row_t r);
    int shifts, first, last, dones, done_cyc, widx, stall, nb;
    logic [WW-1:0] w;
    logic [CL-1:0] exp_chain;
    bit is_abort;
    is_abort = (r.abort_cyc != 0);
    q.delete();
    shifts = 0; first = -1; last = -1; dones = 0; done_cyc = -1; widx = 0; stall = 0;
    for (int cyc = 0; cyc < PASS_CYC; cyc++) begin
      @(posedge prog_clk); #1;
      start_load = (cyc == 0 && (!r.vfy || r.both)) || (r.poke != 0 && cyc == r.poke);
      start_vfy  = (cyc == 0 && (r.vfy || r.both));
      abort      = is_abort && cyc == r.abort_cyc;
      if (stall > 0 && cfg_ready) begin
        cfg_valid = 1'b0;
        stall--;
      end else begin
        cfg_valid = (widx < NW + 1);
        cfg_data  = word(widx, r.flip);
      end
      @(negedge prog_clk);
      if (cfg_valid && cfg_ready) begin
        w  = cfg_data;
        nb = (CL - WW * widx < WW) ? CL - WW * widx : WW;
        for (int b = 0; b < nb; b++) q.push_back(w[b]);
        widx++;
        if (r.stall_len > 0 && widx == r.stall_after) stall = r.stall_len;
      end
      if (ccff_shift) begin
        shifts++;
        if (first < 0) first = cyc;
        last = cyc;
        if (q.size() == 0) check($sformatf("row%0d sb_underrun", idx), 1, 0);
        else check($sformatf("row%0d head", idx), 128'(ccff_head), 128'(q.pop_front()));
      end
      if (done) begin dones++; done_cyc = cyc; end
      if (is_abort && cyc == r.abort_cyc + 1) begin
        check($sformatf("row%0d abort_busy", idx), 128'(busy), 0);
        check($sformatf("row%0d abort_shift", idx), 128'(ccff_shift), 0);
        check($sformatf("row%0d abort_ready", idx), 128'(cfg_ready), 0);
      end
    end
    start_load = 0; start_vfy = 0; abort = 0;
    check($sformatf("row%0d shifts", idx), 128'(shifts), is_abort ? 20 : CL);
    check($sformatf("row%0d first_shift", idx), 128'(first), 2);
    check($sformatf("row%0d last_shift", idx), 128'(last), 128'(r.exp_last));
    check($sformatf("row%0d done_pulses", idx), 128'(dones), is_abort ? 0 : 1);
    check($sformatf("row%0d vfy_err", idx), 128'(vfy_err), 128'(r.exp_vfy));
    check($sformatf("row%0d busy_end", idx), 128'(busy), 0);
    if (!is_abort) begin
      for (int i = 0; i < CL; i++) begin
        w = word(i / WW, r.flip);
        exp_chain[i] = w[i % WW];
      end
      check($sformatf("row%0d done_cyc", idx), 128'(done_cyc), 128'(r.exp_last + 1));
      check($sformatf("row%0d words_acc", idx), 128'(widx), NW);
      check($sformatf("row%0d sb_left", idx), 128'(q.size()), 0);
      check($sformatf("row%0d chain", idx), 128'(chain), 128'(exp_chain));
    end
  endtask

  initial begin
    //        vfy both flip stA stL poke abrt last evf
    rows[0] = '{0, 0, -1, 0, 0,  0,  0, 67, 0};  // plain load
    rows[1] = '{0, 0, -1, 4, 3,  10, 0, 67, 0};  // short stall absorbed by hold reg; start while busy
    rows[2] = '{0, 0, -1, 4, 10, 0,  0, 70, 0};  // long stall drains shifter: 3 bubbles
    rows[3] = '{1, 0, -1, 0, 0,  0,  0, 67, 0};  // clean verify
    rows[4] = '{1, 0, 37, 0, 0,  0,  0, 67, 1};  // verify with bit 37 flipped
    rows[5] = '{0, 0, -1, 0, 0,  0,  21, 21, 1}; // abort at shift 20, vfy_err kept
    rows[6] = '{0, 1, 37, 0, 0,  0,  0, 67, 1};  // both starts -> load, vfy_err not cleared
    rows[7] = '{1, 0, -1, 0, 0,  0,  0, 67, 1};  // chain holds flipped bit -> error
    rows[8] = '{0, 0, -1, 0, 0,  0,  0, 67, 1};  // load leaves vfy_err alone
    rows[9] = '{1, 0, -1, 0, 0,  0,  0, 67, 0};  // verify clears and matches

    pReset_n = 0; start_load = 0; start_vfy = 0; abort = 0; cfg_valid = 0; cfg_data = '0;
    repeat (3) @(posedge prog_clk);
    #1 pReset_n = 1;
    @(negedge prog_clk);
    check("rst_busy", 128'(busy), 0);
    check("rst_ready", 128'(cfg_ready), 0);
    check("rst_shift", 128'(ccff_shift), 0);
    check("rst_head", 128'(ccff_head), 0);
    check("rst_done", 128'(done), 0);
    check("rst_vfy_err", 128'(vfy_err), 0);

    for (int i = 0; i < 10; i++) run_pass(i, rows[i]);

    // Async reset in the middle of a load with all-ones data.
    @(posedge prog_clk); #1 start_load = 1;
    @(posedge prog_clk); #1 start_load = 0; cfg_valid = 1; cfg_data = 8'hFF;
    repeat (4) @(posedge prog_clk);
    @(negedge prog_clk);
    check("mid_shift", 128'(ccff_shift), 1);
    check("mid_head", 128'(ccff_head), 1);
    #2 pReset_n = 0;
    #1;
    check("arst_busy", 128'(busy), 0);
    check("arst_shift", 128'(ccff_shift), 0);
    check("arst_head", 128'(ccff_head), 0);
    check("arst_ready", 128'(cfg_ready), 0);
    @(posedge prog_clk); #1 pReset_n = 1;
    @(negedge prog_clk);
    check("post_rst_busy", 128'(busy), 0);
    check("post_rst_ready", 128'(cfg_ready), 0);
    cfg_valid = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
